// File: rtl/matrix_frame_dma.sv
// Wishbone DMA that copies a frame of pixel words from system memory into the
// LED matrix frame memory: register slave, source read master, matrix write master.
module matrix_frame_dma #(
  parameter int unsigned SRC_AW    = 32,
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [1:0]        adr_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              irq_o,
  output logic              src_cyc_o,
  output logic              src_stb_o,
  output logic [SRC_AW-1:0] src_adr_o,
  output logic [3:0]        src_sel_o,
  input  logic [31:0]       src_dat_i,
  input  logic              src_ack_i,
  output logic              mx_cyc_o,
  output logic              mx_stb_o,
  output logic              mx_we_o,
  output logic [8:0]        mx_adr_o,
  output logic [3:0]        mx_sel_o,
  output logic [31:0]       mx_dat_o,
  input  logic              mx_ack_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t            state, state_nx;
  logic [SRC_AW-1:0] src_reg;
  logic [8:0]        dst_reg;
  logic [9:0]        count_reg;
  logic [9:0]        remaining;
  logic              done, aborted, ie;
  logic              start_pend, abort_pend;
  logic              busy, acc, reg_wr, wr_ctrl;
  logic [31:0]       rd_data;
  logic              unused_ok;

  assign busy      = (state != IDLE);
  assign acc       = cyc_i & stb_i & ~ack_o;
  assign reg_wr    = acc & we_i;
  assign wr_ctrl   = reg_wr & (adr_i == 2'd3);
  assign irq_o     = done & ie;
  assign src_sel_o = 4'hf;
  assign mx_we_o   = 1'b1;
  assign mx_sel_o  = 4'b0111;
  assign unused_ok = ^{sel_i, dat_i};

  always_comb begin
    rd_data = '0;
    case (adr_i)
      2'd0:    rd_data[SRC_AW-1:0] = src_reg;
      2'd1:    rd_data[8:0]        = dst_reg;
      2'd2:    rd_data[9:0]        = count_reg;
      default: rd_data[3:0]        = {ie, done, aborted, busy};
    endcase
  end

  // START is latched on the register-write edge and consumed one cycle later,
  // so the source cycle begins on the edge after the START write's ack.
  always_comb begin
    state_nx  = state;
    src_cyc_o = 1'b0;
    src_stb_o = 1'b0;
    mx_cyc_o  = 1'b0;
    mx_stb_o  = 1'b0;
    case (state)
      IDLE: if (start_pend) state_nx = RD;
      RD: begin
        src_cyc_o = 1'b1;
        src_stb_o = 1'b1;
        if (src_ack_i) state_nx = abort_pend ? IDLE : WR;
      end
      WR: begin
        mx_cyc_o = 1'b1;
        mx_stb_o = 1'b1;
        if (mx_ack_i) begin
          if (abort_pend)              state_nx = IDLE;
          else if (remaining == 10'd1) state_nx = FIN;
          else                         state_nx = RD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ack_o      <= 1'b0;
      dat_o      <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      count_reg  <= '0;
      remaining  <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      ie         <= 1'b0;
      start_pend <= 1'b0;
      abort_pend <= 1'b0;
      src_adr_o  <= '0;
      mx_adr_o   <= '0;
      mx_dat_o   <= '0;
    end else begin
      state <= state_nx;
      ack_o <= acc;
      if (acc && !we_i) dat_o <= rd_data;

      if (reg_wr && !busy && adr_i == 2'd0) src_reg   <= {dat_i[SRC_AW-1:2], 2'b00};
      if (reg_wr && !busy && adr_i == 2'd1) dst_reg   <= dat_i[8:0];
      if (reg_wr && !busy && adr_i == 2'd2) count_reg <= dat_i[9:0];
      if (wr_ctrl) ie <= dat_i[3];
      if (wr_ctrl && dat_i[2]) done <= 1'b0;
      if (wr_ctrl && dat_i[0] && !dat_i[1] && !busy) start_pend <= 1'b1;
      if (wr_ctrl && dat_i[1] && busy) abort_pend <= 1'b1;

      // Later assignments here take priority over the register writes above.
      case (state)
        IDLE: if (start_pend) begin
          start_pend <= 1'b0;
          abort_pend <= 1'b0;
          done       <= 1'b0;
          aborted    <= 1'b0;
          src_adr_o  <= src_reg;
          mx_adr_o   <= dst_reg;
          remaining  <= (count_reg == '0) ? 10'(MAX_WORDS) : count_reg;
        end
        RD: if (src_ack_i) begin
          mx_dat_o <= src_dat_i;
          if (abort_pend) begin
            aborted    <= 1'b1;
            abort_pend <= 1'b0;
          end
        end
        WR: if (mx_ack_i) begin
          src_adr_o <= src_adr_o + SRC_AW'(4);
          mx_adr_o  <= mx_adr_o + 9'd1;
          remaining <= remaining - 10'd1;
          if (abort_pend) begin
            aborted    <= 1'b1;
            abort_pend <= 1'b0;
          end
        end
        default: begin
          done       <= 1'b1;
          abort_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_frame_dma.sv
// Directed bench for matrix_frame_dma with behavioural source memory and
// matrix frame memory responders.
module tb_matrix_frame_dma;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cyc_i, stb_i, we_i;
  logic [1:0]  adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i, dat_o;
  logic        ack_o, irq_o;
  logic        src_cyc_o, src_stb_o;
  logic [31:0] src_adr_o;
  logic [3:0]  src_sel_o;
  logic [31:0] src_dat_i;
  logic        src_ack_i = 1'b0;
  logic        mx_cyc_o, mx_stb_o, mx_we_o;
  logic [8:0]  mx_adr_o;
  logic [3:0]  mx_sel_o;
  logic [31:0] mx_dat_o;
  logic        mx_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  int src_lat = 1;
  int mx_lat  = 2;
  int src_cnt = 0;
  int mx_cnt  = 0;
  int src_reads = 0;
  int stab_err = 0;
  int overlap_err = 0;
  logic [31:0] src_hold_adr;
  logic [8:0]  mx_hold_adr;
  logic [31:0] mx_hold_dat;
  logic [8:0]  wadr[$];
  logic [31:0] wdat[$];
  logic [3:0]  wsel[$];

  matrix_frame_dma #(.SRC_AW(32), .MAX_WORDS(512)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i), .sel_i(sel_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
    .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_adr_o(src_adr_o),
    .src_sel_o(src_sel_o), .src_dat_i(src_dat_i), .src_ack_i(src_ack_i),
    .mx_cyc_o(mx_cyc_o), .mx_stb_o(mx_stb_o), .mx_we_o(mx_we_o),
    .mx_adr_o(mx_adr_o), .mx_sel_o(mx_sel_o), .mx_dat_o(mx_dat_o),
    .mx_ack_i(mx_ack_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_dat(input logic [31:0] a);
    return 32'h00AABB00 + ((a - 32'h100) >> 2) + 32'd1;
  endfunction

  assign src_dat_i = exp_dat(src_adr_o);

  // Source memory: acks src_lat cycles after the strobe is first seen.
  always @(negedge clk) begin
    if (src_cyc_o && src_stb_o && !src_ack_i) begin
      if (src_cnt == 0) src_hold_adr = src_adr_o;
      else if (src_adr_o !== src_hold_adr) stab_err++;
      if (src_cnt == src_lat) begin
        src_ack_i = 1'b1;
        src_reads++;
        src_cnt = 0;
      end else src_cnt++;
    end else begin
      src_ack_i = 1'b0;
      src_cnt = 0;
    end
  end

  // Matrix frame memory: records every accepted write.
  always @(negedge clk) begin
    if (mx_cyc_o && mx_stb_o && !mx_ack_i) begin
      if (mx_cnt == 0) begin
        mx_hold_adr = mx_adr_o;
        mx_hold_dat = mx_dat_o;
      end else if (mx_adr_o !== mx_hold_adr || mx_dat_o !== mx_hold_dat) stab_err++;
      if (mx_cnt == mx_lat) begin
        mx_ack_i = 1'b1;
        wadr.push_back(mx_adr_o);
        wdat.push_back(mx_dat_o);
        wsel.push_back(mx_sel_o);
        mx_cnt = 0;
      end else mx_cnt++;
    end else begin
      mx_ack_i = 1'b0;
      mx_cnt = 0;
    end
  end

  always @(negedge clk) if (src_cyc_o && mx_cyc_o) overlap_err++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_o) break;
    end
    if (!ack_o) check("wb_write ack", {31'd0, ack_o}, 32'd1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_o) break;
    end
    if (!ack_o) check("wb_read ack", {31'd0, ack_o}, 32'd1);
    d = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    wb_write(2'd0, s);
    wb_write(2'd1, d);
    wb_write(2'd2, n);
    wb_write(2'd3, 32'h1);
  endtask

  task automatic wait_writes(input string tag, input int base, input int n);
    for (int i = 0; i < 20000; i++) begin
      if (wadr.size() >= base + n) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check(tag, wadr.size() - base, n);
  endtask

  task automatic check_words(input string tag, input int base, input int n,
                             input logic [31:0] s, input logic [8:0] d);
    for (int i = 0; i < n; i++) begin
      logic [8:0] ea;
      ea = d + 9'(i);
      check({tag, " adr"}, 32'(wadr[base + i]), 32'(ea));
      check({tag, " dat"}, wdat[base + i], exp_dat(s + 32'(4 * i)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, sbase, bad;
    logic [31:0] v;
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; sel_i = 4'hf; dat_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    check("rst src_cyc", {31'd0, src_cyc_o}, 32'd0);
    check("rst mx_cyc", {31'd0, mx_cyc_o}, 32'd0);
    check("rst ack", {31'd0, ack_o}, 32'd0);
    check("rst irq", {31'd0, irq_o}, 32'd0);
    check("rst dat_o", dat_o, 32'd0);
    check("rst src_adr", src_adr_o, 32'd0);
    check("rst mx_adr", 32'(mx_adr_o), 32'd0);
    check("rst mx_dat", mx_dat_o, 32'd0);
    check_reg("rst SRC", 2'd0, 32'd0);
    check_reg("rst CTRL", 2'd3, 32'd0);

    // Basic copy
    base = wadr.size();
    start_xfer(32'h100, 32'h010, 32'd4);
    wait_writes("basic count", base, 4);
    check_words("basic", base, 4, 32'h100, 9'h010);
    check("basic sel", 32'(wsel[base]), 32'h7);
    check_reg("basic CTRL", 2'd3, 32'h4);
    check("basic irq IE=0", {31'd0, irq_o}, 32'd0);
    wb_write(2'd3, 32'h8);
    check("basic irq IE=1", {31'd0, irq_o}, 32'd1);
    check_reg("basic CTRL IE", 2'd3, 32'hC);
    wb_write(2'd3, 32'h4);
    check("irq after clear", {31'd0, irq_o}, 32'd0);
    check_reg("SRC readback", 2'd0, 32'h100);

    // Matrix address wrap
    base = wadr.size();
    start_xfer(32'h200, 32'h1FE, 32'd3);
    wait_writes("wrap count", base, 3);
    check_words("wrap", base, 3, 32'h200, 9'h1FE);

    // Full frame with COUNT=0
    base = wadr.size();
    start_xfer(32'h1000, 32'h000, 32'd0);
    wait_writes("frame count", base, 512);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (wadr[base + i] !== 9'(i) || wdat[base + i] !== exp_dat(32'h1000 + 32'(4 * i))) bad++;
    check("frame words", 32'(bad), 32'd0);
    check("frame src end", src_adr_o, 32'h1800);
    check("frame mx end", 32'(mx_adr_o), 32'd0);
    check_reg("frame CTRL", 2'd3, 32'h4);

    // Slow source slave
    src_lat = 5;
    base = wadr.size();
    start_xfer(32'h300, 32'h020, 32'd3);
    wait_writes("slow count", base, 3);
    check_words("slow", base, 3, 32'h300, 9'h020);
    src_lat = 1;
    check("hold stable", 32'(stab_err), 32'd0);
    check("port overlap", 32'(overlap_err), 32'd0);

    // Busy protection
    base = wadr.size();
    start_xfer(32'h400, 32'h040, 32'd6);
    for (int i = 0; i < 2000 && wadr.size() < base + 1; i++) @(negedge clk);
    wb_write(2'd0, 32'h900);
    wb_write(2'd2, 32'd2);
    wb_write(2'd3, 32'h1);
    wait_writes("busy count", base, 6);
    repeat (40) @(negedge clk);
    check("busy no extra", wadr.size() - base, 32'd6);
    check_words("busy", base, 6, 32'h400, 9'h040);
    check_reg("busy COUNT", 2'd2, 32'd6);
    check_reg("busy SRC", 2'd0, 32'h400);

    // Abort during the write of word 2 of 8
    base = wadr.size();
    sbase = src_reads;
    start_xfer(32'h500, 32'h080, 32'd8);
    for (int i = 0; i < 2000 && !(src_reads == sbase + 2 && mx_stb_o); i++) @(negedge clk);
    wb_write(2'd3, 32'h2);
    repeat (40) @(negedge clk);
    check("abort writes", wadr.size() - base, 32'd2);
    check("abort reads", 32'(src_reads - sbase), 32'd2);
    check_words("abort", base, 2, 32'h500, 9'h080);
    check_reg("abort CTRL", 2'd3, 32'h2);
    base = wadr.size();
    start_xfer(32'h600, 32'h0A0, 32'd2);
    wait_writes("post-abort count", base, 2);
    check_reg("post-abort CTRL", 2'd3, 32'h4);
    wb_write(2'd3, 32'h2);
    check_reg("idle abort CTRL", 2'd3, 32'h4);
    base = wadr.size();
    wb_write(2'd3, 32'h3);
    repeat (20) @(negedge clk);
    check("start+abort writes", wadr.size() - base, 32'd0);
    check_reg("start+abort CTRL", 2'd3, 32'h4);

    // Reset in the middle of a slow read
    wb_write(2'd3, 32'h8);
    check("pre-reset irq", {31'd0, irq_o}, 32'd1);
    src_lat = 5;
    start_xfer(32'h700, 32'h0C0, 32'd4);
    for (int i = 0; i < 200 && !src_cyc_o; i++) @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("reset src_cyc", {31'd0, src_cyc_o}, 32'd0);
    check("reset src_stb", {31'd0, src_stb_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    src_lat = 1;
    check("reset irq", {31'd0, irq_o}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      wb_read(2'(r), v);
      check("reset reg", v, 32'd0);
    end
    repeat (20) @(negedge clk);
    check("reset no mx", {31'd0, mx_cyc_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_frame_dma.md
Name: matrix_frame_dma

Overview:
- Wishbone DMA controller that copies a frame of pixel words from system memory into the LED matrix frame memory.
- Lets the CPU update a whole matrix frame with one register write instead of up to 512 bus writes.
- Three Wishbone ports, all on one clock domain:
  - register slave port, driven by the CPU;
  - read master port, to system memory;
  - write master port, to the matrix frame memory slave. That slave is 512 words, 24-bit RGB in bits [23:0], ack two cycles after request.

Parameters:
- SRC_AW, 32, width of the source byte address.
- MAX_WORDS, 512, words per transfer when COUNT=0; also the matrix address space size.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- cyc_i  in  1  register slave cycle.
- stb_i  in  1  register slave strobe.
- we_i  in  1  register slave write enable.
- adr_i  in  2  register select: 0 SRC, 1 DST, 2 COUNT, 3 CTRL.
- sel_i  in  4  byte enables. Ignored; registers are written whole.
- dat_i  in  32  register write data.
- dat_o  out  32  register read data.
- ack_o  out  1  register slave ack.
- irq_o  out  1  done interrupt, level.
- src_cyc_o  out  1  source master cycle.
- src_stb_o  out  1  source master strobe.
- src_adr_o  out  SRC_AW  source byte address.
- src_sel_o  out  4  source byte enables, constant 4'hf.
- src_dat_i  in  32  source read data.
- src_ack_i  in  1  source ack.
- mx_cyc_o  out  1  matrix master cycle.
- mx_stb_o  out  1  matrix master strobe.
- mx_we_o  out  1  matrix master write enable, constant 1.
- mx_adr_o  out  9  matrix word address.
- mx_sel_o  out  4  matrix byte enables, constant 4'b0111.
- mx_dat_o  out  32  matrix write data.
- mx_ack_i  in  1  matrix ack.

Behaviour:
- Reset values:
  - All cyc/stb outputs, ack_o and irq_o are 0.
  - dat_o=0, src_adr_o=0, mx_adr_o=0, mx_dat_o=0.
  - SRC=0, DST=0, COUNT=0; CTRL flags clear; state IDLE.
  - Reset mid-transfer drops all cyc/stb the next edge. No completion is reported.
- Register slave:
  - ack_o = cyc_i & stb_i & ~ack_o, registered. Each access therefore completes in exactly 1 wait cycle.
  - A write takes effect on the edge where ack_o rises.
- Registers:
  - SRC [SRC_AW-1:0]: word-aligned source byte address; bits [1:0] read 0.
  - DST [8:0]: first matrix word address.
  - COUNT [9:0]: number of words to copy; 0 means MAX_WORDS.
  - CTRL, write side: bit0 START (self-clearing), bit1 ABORT (self-clearing), bit2 DONE (write 1 to clear), bit3 IE.
  - CTRL, read side: bit0 BUSY, bit1 ABORTED, bit2 DONE, bit3 IE.
  - irq_o = DONE & IE.
- While BUSY:
  - Writes to SRC, DST and COUNT are ignored.
  - START is ignored.
  - IE can still be written.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - On START, load the working source address, destination address and remaining count from the registers.
  - Clear DONE and ABORTED, set BUSY, go to RD.
  - src_cyc_o rises the edge after the START write's ack.
- RD:
  - Hold src_cyc/stb with src_adr_o stable until src_ack_i.
  - On ack, capture src_dat_i into mx_dat_o, drop src_cyc/stb, go to WR.
- WR:
  - Hold mx_cyc/stb/we with mx_adr_o and mx_dat_o stable until mx_ack_i.
  - On ack, drop mx_cyc/stb, source address += 4, matrix address += 1 (mod 512), remaining -= 1.
  - If remaining reaches 0, go to FIN; else go to RD.
- FIN: one cycle. BUSY=0, DONE=1, go to IDLE.
- Bus rules:
  - Only one master port is active at a time.
  - Bus cycles are never chained: there is at least one idle cycle between ack and the next stb on the same port.
  - Minimum cost per word with a 2-cycle matrix ack and 1-cycle source ack is about 5 cycles.
- Matrix address wraps 511 -> 0. Source address wraps at 2^SRC_AW.
- ABORT:
  - Takes effect at the next bus-cycle boundary: the in-flight RD or WR completes on its ack first.
  - Then go to IDLE with BUSY=0, ABORTED=1, DONE unchanged.
  - A partial word already read is discarded.
  - ABORT in IDLE has no effect.
- START and ABORT in the same write: ABORT wins, and no transfer starts.
- A DONE-clear write and FIN on the same edge: FIN wins, DONE=1.

Test Plan:
- Basic copy:
  - Stimulus: SRC=0x100, DST=0x010, COUNT=4, START; source returns 0x00AABB01..04.
  - Required: four matrix writes to 0x010..0x013 with data 0x00AABB01..04, sel 0111; then DONE=1, BUSY=0; irq_o=1 only if IE=1.
- Wrap and full frame:
  - DST=0x1FE, COUNT=3: matrix addresses are 0x1FE, 0x1FF, 0x000.
  - COUNT=0: exactly 512 writes occur, and SRC advances by 2048 bytes.
- Slow slaves:
  - Stimulus: source ack delayed 5 cycles, matrix ack 2 cycles.
  - Required: addresses and data are held stable during each wait; src_cyc_o and mx_cyc_o are never high together.
- Busy protection:
  - Stimulus: write SRC and START again mid-transfer.
  - Required: the transfer continues with the original addresses; COUNT readback is unchanged.
- Abort:
  - Stimulus: ABORT during the WR of word 2 of 8.
  - Required: the word-2 write completes, no further cycles occur, ABORTED=1, DONE=0. A following START runs normally and clears ABORTED.
- Reset mid-RD:
  - Stimulus: rst_i high for 1 cycle during RD.
  - Required: src_cyc_o=0 on the next edge, all registers read 0, irq_o=0.
